isp8_spram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32x8 scratchpad distributed RAM between the LatticeMico8 core's external memory port and a second "host" requester (debug/DMA/bridge). It sits between the core's ext_mem_* signals and the scratchpad's Address/Data/WE/Q pins. It serialises accesses with round-robin fairness, returns read data through a registered path, and signals completion with one-cycle ready/ack pulses.

---
 rtl/isp8_spram_arbiter_if.sv | 60 ++++++
 rtl/isp8_spram_arbiter.sv | 112 +++++++++++
 tb/tb_isp8_spram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp8_spram_arbiter_if.sv
// Bus bundle between the scratchpad arbiter, its two requesters and the scratchpad RAM.
// The host_lock signal exists only when ISP8_ARB_HOST_LOCK_EN is defined.
interface isp8_spram_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_wr;
   logic                  cpu_rd;
   logic                  cpu_ready;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic                  host_ack;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [7:0]            conflict_cnt;

`ifdef ISP8_ARB_HOST_LOCK_EN
   logic                  host_lock;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
      input  host_req, host_we, host_addr, host_wdata, host_lock,
      input  ram_q,
      output cpu_ready, cpu_rdata, host_ack, host_rdata,
      output ram_addr, ram_wdata, ram_we, conflict_cnt
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
      output host_req, host_we, host_addr, host_wdata, host_lock,
      output ram_q,
      input  cpu_ready, cpu_rdata, host_ack, host_rdata,
      input  ram_addr, ram_wdata, ram_we, conflict_cnt
   );
`else
   modport slave (
      input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
      input  host_req, host_we, host_addr, host_wdata,
      input  ram_q,
      output cpu_ready, cpu_rdata, host_ack, host_rdata,
      output ram_addr, ram_wdata, ram_we, conflict_cnt
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
      output host_req, host_we, host_addr, host_wdata,
      output ram_q,
      input  cpu_ready, cpu_rdata, host_ack, host_rdata,
      input  ram_addr, ram_wdata, ram_we, conflict_cnt
   );
`endif
endinterface

// File: rtl/isp8_spram_arbiter.sv
// Round-robin arbiter sharing the single-port scratchpad between the core and a host requester.
// Optional ISP8_ARB_HOST_LOCK_EN lets a locked host keep winning ties after its own grant.
module isp8_spram_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   isp8_spram_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CPU_ACC  = 2'd1;
   localparam logic [1:0] HOST_ACC = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]            state;
   logic                  last_host;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  we_q;
   logic                  cpu_ready_q;
   logic                  host_ack_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] host_rdata_q;
   logic [7:0]            conflict_q;
   logic                  cpu_pend;
   logic                  host_pend;
   logic                  pick_host;
   logic                  host_lock_i;

`ifdef ISP8_ARB_HOST_LOCK_EN
   assign host_lock_i = bus.host_lock;
`else
   assign host_lock_i = 1'b0;
`endif

   // Host wins when alone, when the CPU had the last grant, or when a locked host had it.
   always_comb begin
      cpu_pend  = bus.cpu_wr | bus.cpu_rd;
      host_pend = bus.host_req;
      pick_host = host_pend & (~cpu_pend | ~last_host | host_lock_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_host   <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         cpu_ready_q <= 1'b0;
         host_ack_q  <= 1'b0;
         conflict_q  <= 8'd0;
      end else begin
         cpu_ready_q <= 1'b0;
         host_ack_q  <= 1'b0;
         we_q        <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_pend | host_pend) begin
                  if (cpu_pend && host_pend && conflict_q != 8'hFF)
                     conflict_q <= conflict_q + 8'd1;
                  last_host <= pick_host;
                  if (pick_host) begin
                     state   <= HOST_ACC;
                     addr_q  <= bus.host_addr;
                     wdata_q <= bus.host_wdata;
                     we_q    <= bus.host_we;
                  end else begin
                     // A simultaneous write and read strobe is served as a write.
                     state   <= CPU_ACC;
                     addr_q  <= bus.cpu_addr;
                     wdata_q <= bus.cpu_wdata;
                     we_q    <= bus.cpu_wr;
                  end
               end
            end
            CPU_ACC: begin
               state       <= DONE;
               cpu_ready_q <= 1'b1;
            end
            HOST_ACC: begin
               state      <= DONE;
               host_ack_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data is taken from the combinational RAM output only for the owner's reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         if (state == CPU_ACC && !we_q)
            cpu_rdata_q <= bus.ram_q;
         if (state == HOST_ACC && !we_q)
            host_rdata_q <= bus.ram_q;
      end
   end

   assign bus.ram_addr     = addr_q;
   assign bus.ram_wdata    = wdata_q;
   assign bus.ram_we       = we_q;
   assign bus.cpu_ready    = cpu_ready_q;
   assign bus.host_ack     = host_ack_q;
   assign bus.cpu_rdata    = cpu_rdata_q;
   assign bus.host_rdata   = host_rdata_q;
   assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_isp8_spram_arbiter.sv
// Self-checking bench for isp8_spram_arbiter: transaction-timeline model plus directed and random traffic.
// Define ISP8_ARB_HOST_LOCK_EN for both files to exercise the host lock feature.
module tb_isp8_spram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;

   isp8_spram_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

   isp8_spram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scratchpad: asynchronous read, write committed on the rising edge.
   logic [7:0] ram [32];
   assign bus.ram_q = ram[bus.ram_addr];
   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'(i * 7 + 3);
      forever begin
         @(posedge clk);
         if (bus.ram_we === 1'b1) ram[bus.ram_addr] = bus.ram_wdata;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: each grant at cycle g gives access in g+1, completion in g+2, free again in g+3.
   int         t = 0;
   bit         m_act = 0;
   int         m_g = 0;
   bit         m_host = 0;
   bit         m_we = 0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_wdata = '0;
   bit         m_last_host = 1;
   int         m_cnt = 0;
   logic [7:0] exp_mem [32];
   logic [7:0] e_cpu_rdata = '0;
   logic [7:0] e_host_rdata = '0;
   logic       e_we = 0;
   logic       e_cpu_ready = 0;
   logic       e_host_ack = 0;
   bit         cp, hp, lk;

   initial begin
      for (int i = 0; i < 32; i++) exp_mem[i] = 8'(i * 7 + 3);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            t = 0; m_act = 0; m_last_host = 1; m_cnt = 0;
            m_addr = '0; m_wdata = '0; m_we = 0;
            e_cpu_rdata = '0; e_host_rdata = '0;
            e_we = 0; e_cpu_ready = 0; e_host_ack = 0;
         end else begin
            if (m_act && t == m_g + 1) begin
               if (m_we) exp_mem[m_addr] = m_wdata;
               else if (m_host) e_host_rdata = exp_mem[m_addr];
               else e_cpu_rdata = exp_mem[m_addr];
            end
            if (!m_act || t >= m_g + 3) begin
               cp = (bus.cpu_wr | bus.cpu_rd) === 1'b1;
               hp = bus.host_req === 1'b1;
`ifdef ISP8_ARB_HOST_LOCK_EN
               lk = bus.host_lock === 1'b1;
`else
               lk = 0;
`endif
               if (cp || hp) begin
                  if (cp && hp) begin
                     if (m_cnt < 255) m_cnt++;
                     m_host = !m_last_host || lk;
                  end else m_host = hp;
                  m_last_host = m_host;
                  m_act = 1;
                  m_g = t;
                  if (m_host) begin
                     m_we = bus.host_we; m_addr = bus.host_addr; m_wdata = bus.host_wdata;
                  end else begin
                     m_we = bus.cpu_wr; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
                  end
               end
            end
            t++;
            e_we        = m_act && t == m_g + 1 && m_we;
            e_cpu_ready = m_act && t == m_g + 2 && !m_host;
            e_host_ack  = m_act && t == m_g + 2 && m_host;
         end
      end
   end

   // Every out-of-reset cycle the DUT outputs must equal the model.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         check_output("ram_we", bus.ram_we, e_we);
         check_output("ram_addr", bus.ram_addr, m_addr);
         check_output("ram_wdata", bus.ram_wdata, m_wdata);
         check_output("cpu_ready", bus.cpu_ready, e_cpu_ready);
         check_output("host_ack", bus.host_ack, e_host_ack);
         check_output("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
         check_output("host_rdata", bus.host_rdata, e_host_rdata);
         check_output("conflict_cnt", bus.conflict_cnt, m_cnt);
      end
   end

   task automatic apply_stimulus(input bit cwr, input bit crd, input logic [4:0] caddr, input logic [7:0] cdata,
                                 input bit hreq, input bit hwe, input logic [4:0] haddr, input logic [7:0] hdata);
      bus.cpu_wr = cwr; bus.cpu_rd = crd; bus.cpu_addr = caddr; bus.cpu_wdata = cdata;
      bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdata = hdata;
   endtask

   task automatic do_reset();
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ISP8_ARB_HOST_LOCK_EN
      bus.host_lock = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int owners [$];
   int times [$];
   int n;
   bit cb, hb;
   int r;

   initial begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ISP8_ARB_HOST_LOCK_EN
      bus.host_lock = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_output("rst ram_we", bus.ram_we, 0);
      check_output("rst ram_addr", bus.ram_addr, 0);
      check_output("rst ram_wdata", bus.ram_wdata, 0);
      check_output("rst cpu_ready", bus.cpu_ready, 0);
      check_output("rst host_ack", bus.host_ack, 0);
      check_output("rst cpu_rdata", bus.cpu_rdata, 0);
      check_output("rst host_rdata", bus.host_rdata, 0);
      check_output("rst conflict_cnt", bus.conflict_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] lone CPU write then host read");
      apply_stimulus(1, 0, 5'h03, 8'hA5, 0, 0, 0, 0);
      @(negedge clk);
      check_output("wr N+1 ram_we", bus.ram_we, 1);
      check_output("wr N+1 ram_addr", bus.ram_addr, 5'h03);
      check_output("wr N+1 ram_wdata", bus.ram_wdata, 8'hA5);
      check_output("wr N+1 cpu_ready", bus.cpu_ready, 0);
      @(negedge clk);
      check_output("wr N+2 cpu_ready", bus.cpu_ready, 1);
      check_output("wr N+2 host_ack", bus.host_ack, 0);
      check_output("wr N+2 ram_we", bus.ram_we, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 5'h03, 8'h00);
      @(negedge clk);
      check_output("wr N+3 cpu_ready", bus.cpu_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check_output("rd host_ack", bus.host_ack, 1);
      check_output("rd host_rdata", bus.host_rdata, 8'hA5);
      check_output("rd cpu_rdata kept", bus.cpu_rdata, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("[TB] simultaneous CPU read and host write after reset");
      do_reset();
      apply_stimulus(0, 1, 5'h03, 8'h00, 1, 1, 5'h07, 8'h5C);
      @(negedge clk);
      check_output("tie first ram_addr", bus.ram_addr, 5'h03);
      @(negedge clk);
      check_output("tie cpu_ready", bus.cpu_ready, 1);
      check_output("tie host_ack early", bus.host_ack, 0);
      check_output("tie cpu_rdata", bus.cpu_rdata, 8'hA5);
      bus.cpu_rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("tie host ram_we", bus.ram_we, 1);
      check_output("tie host ram_addr", bus.ram_addr, 5'h07);
      @(negedge clk);
      check_output("tie host_ack", bus.host_ack, 1);
      check_output("tie conflict_cnt", bus.conflict_cnt, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("[TB] continuous dual contention");
      do_reset();
      apply_stimulus(0, 1, 5'h05, 8'h00, 1, 0, 5'h06, 8'h00);
      owners.delete(); times.delete();
      for (int c = 0; c < 60 && owners.size() < 8; c++) begin
         @(negedge clk);
         if (bus.cpu_ready === 1'b1) begin owners.push_back(0); times.push_back(c); end
         if (bus.host_ack === 1'b1) begin owners.push_back(1); times.push_back(c); end
      end
      check_output("alt count", owners.size(), 8);
      check_output("alt conflict_cnt", bus.conflict_cnt, 8);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      n = owners.size();
      for (int i = 0; i < n; i++) check_output("alt owner", owners[i], i % 2);
      for (int i = 1; i < n; i++) check_output("alt spacing", times[i] - times[i-1], 3);
      @(negedge clk);

      $display("[TB] reset during CPU access");
      do_reset();
      apply_stimulus(1, 0, 5'h09, 8'h3C, 0, 0, 0, 0);
      @(negedge clk);
      check_output("abort pre ram_we", bus.ram_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check_output("abort ram_we", bus.ram_we, 0);
      check_output("abort cpu_ready", bus.cpu_ready, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(0, 1, 5'h09, 8'h00, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check_output("abort after cpu_ready", bus.cpu_ready, 1);
      check_output("abort after cpu_rdata", bus.cpu_rdata, 8'h42);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

`ifdef ISP8_ARB_HOST_LOCK_EN
      $display("[TB] host lock");
      do_reset();
      bus.host_lock = 1'b1;
      apply_stimulus(0, 1, 5'h01, 8'h00, 1, 0, 5'h02, 8'h00);
      owners.delete();
      for (int c = 0; c < 60 && owners.size() < 5; c++) begin
         @(negedge clk);
         if (bus.cpu_ready === 1'b1) owners.push_back(0);
         if (bus.host_ack === 1'b1) owners.push_back(1);
         if (owners.size() == 4) bus.host_lock = 1'b0;
      end
      check_output("lock count", owners.size(), 5);
      n = owners.size();
      for (int i = 0; i < n; i++) check_output("lock owner", owners[i], (i < 4) ? 1 : 0);
      check_output("lock conflict_cnt", bus.conflict_cnt, 5);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`endif

      $display("[TB] random traffic");
      do_reset();
      cb = 0; hb = 0;
      repeat (3000) begin
         @(negedge clk);
         if (cb && bus.cpu_ready === 1'b1) begin cb = 0; bus.cpu_wr = 0; bus.cpu_rd = 0; end
         if (hb && bus.host_ack === 1'b1) begin hb = 0; bus.host_req = 0; end
         if (!cb && $urandom_range(0, 3) == 0) begin
            cb = 1;
            r = $urandom_range(0, 2);
            bus.cpu_wr = (r != 1);
            bus.cpu_rd = (r != 0);
            bus.cpu_addr = 5'($urandom_range(0, 31));
            bus.cpu_wdata = 8'($urandom_range(0, 255));
         end
         if (hb) begin
            bus.host_we = 1'($urandom_range(0, 1));
            bus.host_addr = 5'($urandom_range(0, 31));
            bus.host_wdata = 8'($urandom_range(0, 255));
         end else if ($urandom_range(0, 3) == 0) begin
            hb = 1;
            bus.host_req = 1'b1;
            bus.host_we = 1'($urandom_range(0, 1));
            bus.host_addr = 5'($urandom_range(0, 31));
            bus.host_wdata = 8'($urandom_range(0, 255));
         end
`ifdef ISP8_ARB_HOST_LOCK_EN
         bus.host_lock = 1'($urandom_range(0, 1));
`endif
      end
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
